// File: rtl/wb_pkg.sv
// Shared encodings for the write-back sequencer: FSM states, ctrlword bit
// positions and result-memory slot selects.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_LAST  = 2'd1,
        ST_WR_FIRST = 2'd2
    } wb_state_e;

    localparam int CW_WAR1  = 4;
    localparam int CW_WAR0  = 3;
    localparam int CW_WRR1  = 2;
    localparam int CW_WRR0  = 1;
    localparam int CW_SELAR = 0;

    localparam logic MEM_SEL_SLOT0 = 1'b0;
    localparam logic MEM_SEL_SLOT1 = 1'b1;

endpackage

// File: rtl/wb_sequencer.sv
// Two-slot write-back controller: captures FU0/FU1 completions and drains them
// into the single-port result memory. Define WB_RR_ORDER_EN for alternating dual-drain order.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int ADDRSIZE = 5,
    parameter int CTRL_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fu0_valid,
    input  logic              fu1_valid,
    input  logic              dp_swap,
    output logic              wb_ready,
    output logic [CTRL_W-1:0] ctrlword,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [15:0]       dual_cnt
);

    if (CTRL_W != 5 || ADDRSIZE < 1) begin : g_param_check
        $error("wb_sequencer: CTRL_W must be 5 and ADDRSIZE positive");
    end

    wb_state_e   state_q, state_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_sel_q, mem_sel_d;
    logic [15:0] dual_cnt_q, dual_cnt_d;
    logic        accept0, accept1;
    logic        first_slot;

`ifdef WB_RR_ORDER_EN
    logic        order_q, order_d;
    assign first_slot = order_q;
`else
    assign first_slot = MEM_SEL_SLOT0;
`endif

    always_comb begin
        wb_ready = rst_n & (state_q != ST_WR_FIRST);
        accept0  = fu0_valid & wb_ready;
        accept1  = fu1_valid & wb_ready;

        ctrlword           = '0;
        ctrlword[CW_WAR0]  = accept0;
        ctrlword[CW_WRR0]  = accept0;
        ctrlword[CW_WAR1]  = accept1;
        ctrlword[CW_WRR1]  = accept1;
        ctrlword[CW_SELAR] = dp_swap & (accept0 | accept1);
    end

    always_comb begin
        state_d    = ST_IDLE;
        mem_we_d   = 1'b0;
        mem_sel_d  = mem_sel_q;
        dual_cnt_d = dual_cnt_q;
`ifdef WB_RR_ORDER_EN
        order_d    = order_q;
`endif
        if (accept0 && accept1) begin
            state_d    = ST_WR_FIRST;
            mem_we_d   = 1'b1;
            mem_sel_d  = first_slot;
            dual_cnt_d = (dual_cnt_q == 16'hFFFF) ? dual_cnt_q : dual_cnt_q + 16'd1;
`ifdef WB_RR_ORDER_EN
            order_d    = ~order_q;
`endif
        end else if (accept0 || accept1) begin
            state_d   = ST_WR_LAST;
            mem_we_d  = 1'b1;
            mem_sel_d = accept1 ? MEM_SEL_SLOT1 : MEM_SEL_SLOT0;
        end else if (state_q == ST_WR_FIRST) begin
            // second half of a dual drain always writes the slot not yet written
            state_d   = ST_WR_LAST;
            mem_we_d  = 1'b1;
            mem_sel_d = ~mem_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mem_we_q   <= 1'b0;
            mem_sel_q  <= MEM_SEL_SLOT0;
            dual_cnt_q <= '0;
`ifdef WB_RR_ORDER_EN
            order_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_we_q   <= mem_we_d;
            mem_sel_q  <= mem_sel_d;
            dual_cnt_q <= dual_cnt_d;
`ifdef WB_RR_ORDER_EN
            order_q    <= order_d;
`endif
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_sel  = mem_sel_q;
    assign dual_cnt = dual_cnt_q;

endmodule
